addsub_seq32: RTL

Multi-cycle 32-bit add/subtract unit that time-shares one SLICE-bit ripple-carry adder slice across WIDTH/SLICE consecutive cycles. The block holds the carry between slices and produces carry, overflow and zero flags. It sits between an operand producer and a result consumer, with valid/ready handshakes on both sides. It trades latency for area against a full-width ripple adder.

---
 rtl/addsub_pkg.sv | 19 +
 rtl/addsub_slice.sv | 26 ++
 rtl/addsub_seq32.sv | 131 +++++++++++++
 3 files changed

// File: rtl/addsub_pkg.sv
// Shared types and constants for the sequential add/subtract unit.
package addsub_pkg;

  // Controller states: waiting for operands, crunching slices, holding result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Operation encoding on the op input.
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Default datapath geometry.
  localparam int DEF_WIDTH = 32;
  localparam int DEF_SLICE = 8;

endpackage

// File: rtl/addsub_slice.sv
// Combinational SLICE-bit ripple-carry adder; the only arithmetic in the unit.
module addsub_slice
  import addsub_pkg::*;
#(
  parameter int SLICE = DEF_SLICE
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] sum,
  output logic             cout
);

  logic [SLICE:0] w_c;

  assign w_c[0] = cin;

  // One full adder per bit, carry rippling upward.
  for (genvar gi = 0; gi < SLICE; gi++) begin : g_bit
    assign sum[gi]    = a[gi] ^ b[gi] ^ w_c[gi];
    assign w_c[gi+1]  = (a[gi] & b[gi]) | (w_c[gi] & (a[gi] ^ b[gi]));
  end

  assign cout = w_c[SLICE];

endmodule

// File: rtl/addsub_seq32.sv
// Multi-cycle add/subtract: one SLICE-bit adder reused over WIDTH/SLICE cycles,
// least-significant slice first, with valid/ready handshakes on both sides.
module addsub_seq32
  import addsub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SLICE = DEF_SLICE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             busy
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(NSLICE - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_y;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic             r_cout;
  logic             r_ovf;
  logic             r_zero;

  logic [SLICE-1:0] w_sum;
  logic             w_slice_cout;
  logic             w_last;
  logic [WIDTH-1:0] w_y_shift;

  addsub_slice #(.SLICE(SLICE)) u_slice (
    .a    (r_a[SLICE-1:0]),
    .b    (r_b[SLICE-1:0]),
    .cin  (r_carry),
    .sum  (w_sum),
    .cout (w_slice_cout)
  );

  assign w_last    = (r_cnt == LAST_CNT);
  // New slice enters at the top; after NSLICE shifts the full result is aligned.
  assign w_y_shift = {w_sum, r_y[WIDTH-1:SLICE]};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state and handshake decode; outputs depend on registered state only.
  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    busy         = 1'b1;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) w_state_next = RUN;
      end
      RUN: begin
        if (w_last) w_state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Operand capture, slice-by-slice shifting, and flag capture on the last slice.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_y     <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_zero  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            // Subtract is a + ~b + 1: invert here, carry-in supplies the +1.
            r_b     <= (op == OP_SUB) ? ~b : b;
            r_carry <= (op == OP_SUB);
            r_cnt   <= '0;
          end
        end
        RUN: begin
          r_a     <= r_a >> SLICE;
          r_b     <= r_b >> SLICE;
          r_y     <= w_y_shift;
          r_carry <= w_slice_cout;
          r_cnt   <= r_cnt + CW'(1);
          if (w_last) begin
            r_cout <= w_slice_cout;
            // Remaining A/B low bits are now the operand sign bits.
            r_ovf  <= (r_a[SLICE-1] == r_b[SLICE-1]) && (w_sum[SLICE-1] != r_a[SLICE-1]);
            r_zero <= (w_y_shift == '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign y    = r_y;
  assign cout = r_cout;
  assign ovf  = r_ovf;
  assign zero = r_zero;

endmodule
